// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames one byte (start, 7/8 data bits LSB first, optional parity,
// 1 or 2 stop bits) onto tx, advancing one bit per xmit_pulse. Parity built only with UART_TX_PARITY_EN.
module uart_tx_serializer #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       xmit_pulse,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam logic LP_TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t     r_state, w_next_state;
    logic [7:0] r_hold;
    logic       r_full;
    logic [7:0] r_shift;
    logic [2:0] r_cnt, w_next_cnt;
    logic       r_stop_cnt, w_next_stop_cnt;
    logic       r_tx, w_next_tx;
    logic       r_bit8;
    logic       w_load;
    logic       w_shift_en;
    logic       w_last_data;
    logic       w_last_stop;

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_parity;
    logic w_parity;

    // Parity covers only the bits that will actually be sent.
    assign w_parity = (^(bit8 ? r_hold : {1'b0, r_hold[6:0]})) ^ odd_n_even;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = parity_en ^ odd_n_even;
`endif

    assign w_last_data = (r_cnt == (r_bit8 ? 3'd7 : 3'd6));
    assign w_last_stop = !LP_TWO_STOP || r_stop_cnt;

    // NOTE: holding data is reset along with its flag so no stale byte survives a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_hold <= '0;
        end else if (w_load) begin
            r_full <= 1'b0;
        end else if (tx_valid && !r_full) begin
            r_full <= 1'b1;
            r_hold <= tx_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_cnt      <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tx       <= w_next_tx;
            r_cnt      <= w_next_cnt;
            r_stop_cnt <= w_next_stop_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_bit8   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par_en <= 1'b0;
            r_parity <= 1'b0;
`endif
        end else if (w_load) begin
            r_shift  <= r_hold;
            r_bit8   <= bit8;
`ifdef UART_TX_PARITY_EN
            r_par_en <= parity_en;
            r_parity <= w_parity;
`endif
        end else if (w_shift_en) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state    = r_state;
        w_next_tx       = r_tx;
        w_next_cnt      = r_cnt;
        w_next_stop_cnt = r_stop_cnt;
        w_load          = 1'b0;
        w_shift_en      = 1'b0;
        if (xmit_pulse) begin
            case (r_state)
                S_IDLE: begin
                    if (r_full) begin
                        w_load       = 1'b1;
                        w_next_tx    = 1'b0;
                        w_next_state = S_START;
                    end
                end
                S_START: begin
                    w_next_tx    = r_shift[0];
                    w_shift_en   = 1'b1;
                    w_next_cnt   = '0;
                    w_next_state = S_DATA;
                end
                S_DATA: begin
                    if (!w_last_data) begin
                        w_next_tx  = r_shift[0];
                        w_shift_en = 1'b1;
                        w_next_cnt = r_cnt + 3'd1;
                    end
`ifdef UART_TX_PARITY_EN
                    else if (r_par_en) begin
                        w_next_tx    = r_parity;
                        w_next_state = S_PARITY;
                    end
`endif
                    else begin
                        w_next_tx       = 1'b1;
                        w_next_stop_cnt = 1'b0;
                        w_next_state    = S_STOP;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    w_next_tx       = 1'b1;
                    w_next_stop_cnt = 1'b0;
                    w_next_state    = S_STOP;
                end
`endif
                S_STOP: begin
                    // A byte already waiting starts straight after the last stop bit.
                    if (!w_last_stop) begin
                        w_next_stop_cnt = 1'b1;
                    end else if (r_full) begin
                        w_load       = 1'b1;
                        w_next_tx    = 1'b0;
                        w_next_state = S_START;
                    end else begin
                        w_next_tx    = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_tx    = 1'b1;
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = ~r_full;
    assign tx_busy  = (r_state != S_IDLE) | r_full;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: one instance with 1 stop bit, one with 2,
// per-instance scoreboard of expected line levels sampled at every xmit_pulse.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       xmit_pulse;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic [7:0] tx_data;
    logic       valid1, valid2;
    logic       ready1, ready2;
    logic       tx1, tx2;
    logic       busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    logic exp1_q[$];
    logic pend1_q[$];
    logic exp2_q[$];
    logic pend2_q[$];

    uart_tx_serializer #(.STOP_BITS(1)) u_dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .xmit_pulse (xmit_pulse),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .tx_data    (tx_data),
        .tx_valid   (valid1),
        .tx_ready   (ready1),
        .tx         (tx1),
        .tx_busy    (busy1)
    );

    uart_tx_serializer #(.STOP_BITS(2)) u_dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .xmit_pulse (xmit_pulse),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .tx_data    (tx_data),
        .tx_valid   (valid2),
        .tx_ready   (ready2),
        .tx         (tx2),
        .tx_busy    (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud generator stand-in: one-cycle strobe every 16 clocks, changed just after posedge.
    initial begin
        int pc;
        pc = 0;
        xmit_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pc = (pc == 15) ? 0 : pc + 1;
            xmit_pulse = (pc == 15);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, required end before 1 ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level during each bit time is sampled on the cycle of the pulse that ends it.
    always @(negedge clk) begin
        if (reset_n && xmit_pulse) begin
            if (exp1_q.size() > 0) check("tx1_bit", tx1, exp1_q.pop_front());
            else                   check("tx1_idle", tx1, 1);
            if (exp1_q.size() == 0 && pend1_q.size() > 0) begin
                exp1_q = pend1_q;
                pend1_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && xmit_pulse) begin
            if (exp2_q.size() > 0) check("tx2_bit", tx2, exp2_q.pop_front());
            else                   check("tx2_idle", tx2, 1);
            if (exp2_q.size() == 0 && pend2_q.size() > 0) begin
                exp2_q = pend2_q;
                pend2_q.delete();
            end
        end
    end

    task automatic push_bit(input bit which, input logic b);
        if (which) pend2_q.push_back(b);
        else       pend1_q.push_back(b);
    endtask

    // Expected frame for byte d under the current configuration inputs.
    task automatic push_frame(input bit which, input logic [7:0] d);
        int         nbits;
        logic [7:0] m;
        logic       par;
        nbits = bit8 ? 8 : 7;
        m     = d;
        if (!bit8) m[7] = 1'b0;
        par = (^m) ^ odd_n_even;
        push_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) push_bit(which, d[i]);
        if (PAR_BUILT && parity_en) push_bit(which, par);
        for (int i = 0; i < (which ? 2 : 1); i++) push_bit(which, 1'b1);
    endtask

    task automatic write_byte(input bit which, input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        if (which) valid2 = 1'b1;
        else       valid1 = 1'b1;
        @(posedge clk);
        #1;
        valid1 = 1'b0;
        valid2 = 1'b0;
        push_frame(which, d);
    endtask

    task automatic wait_pulse();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (xmit_pulse) break;
        end
    endtask

    task automatic wait_ready(input bit which);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((which ? ready2 : ready1) === 1'b1) break;
        end
        check("ready_wait", which ? ready2 : ready1, 1);
    endtask

    task automatic wait_drain(input bit which);
        int left;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            left = which ? (exp2_q.size() + pend2_q.size()) : (exp1_q.size() + pend1_q.size());
            if (left == 0 && (which ? busy2 : busy1) === 1'b0) break;
        end
        check("drain_queue", left, 0);
        check("drain_busy", which ? busy2 : busy1, 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        bit8       = 1'b1;
        parity_en  = 1'b0;
        odd_n_even = 1'b0;
        tx_data    = 8'h00;
        valid1     = 1'b0;
        valid2     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx1", tx1, 1);
        check("rst_ready1", ready1, 1);
        check("rst_busy1", busy1, 0);
        check("rst_tx2", tx2, 1);
        check("rst_busy2", busy2, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1, 0x55
        write_byte(0, 8'h55);
        check("full_ready1", ready1, 0);
        check("full_busy1", busy1, 1);
        wait_drain(0);

        // 8 bits even parity, 0xA3
        parity_en = 1'b1;
        write_byte(0, 8'hA3);
        wait_drain(0);

        // 8 bits odd parity, 0xA3; configuration scrambled mid-frame
        odd_n_even = 1'b1;
        write_byte(0, 8'hA3);
        repeat (4) wait_pulse();
        odd_n_even = 1'b0;
        bit8       = 1'b0;
        parity_en  = 1'b0;
        wait_drain(0);

        // 7 bits even parity, 0xFF
        bit8       = 1'b0;
        parity_en  = 1'b1;
        odd_n_even = 1'b0;
        write_byte(0, 8'hFF);
        wait_drain(0);

        // Back-to-back 0x01 then 0x80, 8N1
        bit8      = 1'b1;
        parity_en = 1'b0;
        write_byte(0, 8'h01);
        wait_pulse();
        check("b2b_ready_before", ready1, 0);
        @(negedge clk);
        check("b2b_ready_after", ready1, 1);
        check("b2b_start_latency", tx1, 0);
        write_byte(0, 8'h80);
        check("b2b_ready_full", ready1, 0);
        wait_drain(0);

        // Two stop bits: 0x00 twice back-to-back
        write_byte(1, 8'h00);
        wait_ready(1);
        write_byte(1, 8'h00);
        check("stop2_ready_full", ready2, 0);
        wait_drain(1);

        // Reset during bit 3 of 0xF0 with a second byte held
        write_byte(0, 8'hF0);
        wait_pulse();
        wait_ready(0);
        write_byte(0, 8'hC3);
        repeat (4) wait_pulse();
        @(posedge clk);
        #3;
        check("mid_bit3_low", tx1, 0);
        check("mid_held", ready1, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx", tx1, 1);
        check("mid_rst_ready", ready1, 1);
        check("mid_rst_busy", busy1, 0);
        exp1_q.delete();
        pend1_q.delete();
        exp2_q.delete();
        pend2_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_busy", busy1, 0);
        check("post_rst_tx", tx1, 1);
        write_byte(0, 8'h3C);
        wait_drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
